// File: rtl/projectiles_pkg.sv
// Shared constants, scheduler state encoding and cooldown reload arithmetic
// for the enemy projectile scheduler.
package projectiles_pkg;
  localparam int ENEMY_BIKES_COUNT_DEF = 8;
  localparam int MAX_ACTIVE_DEF        = 3;
  localparam int BASE_COOLDOWN_DEF     = 60;
  localparam int LEVEL_STEP_DEF        = 4;
  localparam int MIN_COOLDOWN_DEF      = 8;

  typedef enum logic [1:0] {IDLE, COOLDOWN, ARBITRATE, FIRE} sched_state_e;

  // Signed math so high levels clamp to the floor instead of wrapping.
  function automatic logic [7:0] reload_value(input logic [3:0] lvl, input int base,
                                              input int step, input int minc);
    int v;
    v = base - int'(lvl) * step;
    if (v < minc) v = minc;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction
endpackage

// File: rtl/enemy_shoot_scheduler_if.sv
// Frame/request/fire signal bundle between the game logic and the shoot scheduler.
interface enemy_shoot_scheduler_if
  import projectiles_pkg::*;
#(
  parameter int N = ENEMY_BIKES_COUNT_DEF
);
  logic         startOfFrame;
  logic [N-1:0] shootWishVector;
  logic [N-1:0] projectileBusyVector;
  logic [3:0]   level;
  logic         endLevel;
  logic [N-1:0] shootRequestEnemy;
  logic         schedulerBusy;

  modport master (output startOfFrame, shootWishVector, projectileBusyVector, level, endLevel,
                  input  shootRequestEnemy, schedulerBusy);
  modport slave  (input  startOfFrame, shootWishVector, projectileBusyVector, level, endLevel,
                  output shootRequestEnemy, schedulerBusy);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after last_i+1, wrapping.
module rr_arbiter #(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          valid_o
);
  int idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    idx       = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last_i) + off) % N;
      if (!valid_o && req_i[idx]) begin
        valid_o    = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/enemy_shoot_scheduler.sv
// Paces enemy shots: per-level frame cooldown, then a round-robin pick among idle bikes.
// Optional SHOOT_JITTER_EN adds 0..7 frames of LFSR jitter to every reload.
module enemy_shoot_scheduler
  import projectiles_pkg::*;
#(
  parameter int ENEMY_BIKES_COUNT = ENEMY_BIKES_COUNT_DEF,
  parameter int MAX_ACTIVE        = MAX_ACTIVE_DEF,
  parameter int BASE_COOLDOWN     = BASE_COOLDOWN_DEF,
  parameter int LEVEL_STEP        = LEVEL_STEP_DEF,
  parameter int MIN_COOLDOWN      = MIN_COOLDOWN_DEF
) (
  input logic clk,
  input logic reset,
  enemy_shoot_scheduler_if.slave bus
);
  localparam int N  = ENEMY_BIKES_COUNT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  sched_state_e  state_q;
  logic [7:0]    cnt_q;
  logic [IW-1:0] last_q;
  logic [N-1:0]  shoot_q;

  logic [N-1:0]  elig, gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_vld;
  int            active_cnt;
  logic [7:0]    base_reload, cnt_reload_d;

  assign elig        = bus.shootWishVector & ~bus.projectileBusyVector;
  assign base_reload = reload_value(bus.level, BASE_COOLDOWN, LEVEL_STEP, MIN_COOLDOWN);

  always_comb begin
    active_cnt = 0;
    for (int i = 0; i < N; i++)
      if (bus.projectileBusyVector[i]) active_cnt++;
  end

`ifdef SHOOT_JITTER_EN
  logic [7:0] lfsr_q;
  logic [8:0] jit_sum;

  always_comb begin
    jit_sum      = {1'b0, base_reload} + {6'd0, lfsr_q[2:0]};
    cnt_reload_d = jit_sum[8] ? 8'hFF : jit_sum[7:0];
  end

  // Maximal-length taps 8,6,5,4; free-runs on frame ticks in every state.
  always_ff @(posedge clk) begin
    if (reset)             lfsr_q <= 8'hA5;
    else if (bus.startOfFrame) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
`else
  assign cnt_reload_d = base_reload;
`endif

  rr_arbiter #(.N(N)) u_rr (
    .req_i     (elig),
    .last_i    (last_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .valid_o   (gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(N - 1);
      shoot_q <= '0;
    end else begin
      shoot_q <= '0;
      if (bus.endLevel) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= COOLDOWN;
            cnt_q   <= cnt_reload_d;
          end
          COOLDOWN: begin
            if (cnt_q == 8'd0)         state_q <= ARBITRATE;
            else if (bus.startOfFrame) cnt_q   <= cnt_q - 8'd1;
          end
          ARBITRATE: begin
            if (gnt_vld && active_cnt < MAX_ACTIVE) begin
              shoot_q <= gnt;
              last_q  <= gnt_idx;
              state_q <= FIRE;
            end
          end
          FIRE: begin
            state_q <= COOLDOWN;
            cnt_q   <= cnt_reload_d;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.shootRequestEnemy = shoot_q;
  assign bus.schedulerBusy     = (state_q != IDLE);
endmodule
